// File: rtl/next_pc_unit_if.sv
// Next-PC unit bus: PC-side inputs and next-PC/RAS status outputs.
// master drives PC/control and observes PCin/status; slave is the unit.
interface next_pc_unit_if #(
  parameter int Width = 8,
  parameter int Depth = 4
);
  localparam int CW = $clog2(Depth) + 1;

  logic [Width-1:0] PC;
  logic             Stall;
  logic             Branch;
  logic             Zero;
  logic [Width-1:0] Offset;
  logic             Jump;
  logic             Call;
  logic             Ret;
  logic [Width-1:0] Target;
  logic [Width-1:0] PCin;
  logic             Empty;
  logic             Full;
  logic [CW-1:0]    Count;
  logic             StackErr;

  modport master (
    output PC, Stall, Branch, Zero, Offset,
    output Jump, Call, Ret, Target,
    input  PCin, Empty, Full, Count, StackErr
  );

  modport slave (
    input  PC, Stall, Branch, Zero, Offset,
    input  Jump, Call, Ret, Target,
    output PCin, Empty, Full, Count, StackErr
  );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC select with circular return-address stack.
// NEXT_PC_STICKY_ERR_EN: StackErr holds until Reset instead of pulsing.
module next_pc_unit #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input logic            CLK,
  input logic            Reset,
  next_pc_unit_if.slave  bus
);
  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CntMax = CW'(Depth);

  logic [Width-1:0] stack_q [Depth];
  logic [Width-1:0] stack_d [Depth];
  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic [Width-1:0] pc_inc;
  logic [Width-1:0] top;
  logic             empty;
  logic             full;

  assign pc_inc = bus.PC + Width'(1);
  assign top    = stack_q[sp_q - PW'(1)];
  assign empty  = (count_q == '0);
  assign full   = (count_q == CntMax);

  always_comb begin
    bus.PCin = pc_inc;
    if (Reset)                        bus.PCin = '0;
    else if (bus.Stall)               bus.PCin = bus.PC;
    else if (bus.Ret)                 bus.PCin = empty ? pc_inc : top;
    else if (bus.Call || bus.Jump)    bus.PCin = bus.Target;
    else if (bus.Branch && bus.Zero)  bus.PCin = pc_inc + bus.Offset;
  end

  always_comb begin
    stack_d = stack_q;
    sp_d    = sp_q;
    count_d = count_q;
`ifdef NEXT_PC_STICKY_ERR_EN
    err_d   = err_q;
`else
    err_d   = 1'b0;
`endif
    if (bus.Stall) begin
      err_d = err_q;
    end else if (bus.Ret) begin
      // a simultaneous Call is dropped but still flagged
      if (empty) begin
        err_d = 1'b1;
      end else begin
        sp_d    = sp_q - PW'(1);
        count_d = count_q - CW'(1);
      end
      if (bus.Call) err_d = 1'b1;
    end else if (bus.Call) begin
      stack_d[sp_q] = pc_inc;
      sp_d          = sp_q + PW'(1);
      if (full) err_d   = 1'b1;
      else      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < Depth; i++) stack_q[i] <= '0;
      sp_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stack_q <= stack_d;
      sp_q    <= sp_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.Empty    = empty;
  assign bus.Full     = full;
  assign bus.Count    = count_q;
  assign bus.StackErr = err_q;
endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit (Width=8, Depth=4).
module tb_next_pc_unit;
`ifdef NEXT_PC_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  typedef struct {
    string      nm;
    logic [7:0] pc;
    logic [2:0] cnt;
    logic       emp;
    logic       full;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  next_pc_unit_if #(.Width(8), .Depth(4)) bus ();

  next_pc_unit #(.Width(8), .Depth(4)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  task automatic cyc(
    input string nm,
    input logic r, input logic [7:0] pc,
    input logic st, input logic br, input logic z,
    input logic [7:0] off,
    input logic j, input logic c, input logic rt,
    input logic [7:0] tgt,
    input logic [7:0] e_pc, input logic [2:0] e_cnt,
    input logic e_emp, input logic e_full, input logic e_err
  );
    exp_t e;
    rst        = r;
    bus.PC     = pc;
    bus.Stall  = st;
    bus.Branch = br;
    bus.Zero   = z;
    bus.Offset = off;
    bus.Jump   = j;
    bus.Call   = c;
    bus.Ret    = rt;
    bus.Target = tgt;
    sb.push_back('{nm, e_pc, e_cnt, e_emp, e_full, e_err});
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (bus.PCin !== e.pc) begin
      n_err++;
      $display("FAIL %s pcin got %h want %h", e.nm, bus.PCin, e.pc);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.Count !== e.cnt) begin
      n_err++;
      $display("FAIL %s count got %0d want %0d", e.nm, bus.Count, e.cnt);
    end
    n_vec++;
    if (bus.Empty !== e.emp || bus.Full !== e.full) begin
      n_err++;
      $display("FAIL %s empty/full got %b%b want %b%b",
               e.nm, bus.Empty, bus.Full, e.emp, e.full);
    end
    n_vec++;
    if (bus.StackErr !== e.err) begin
      n_err++;
      $display("FAIL %s stackerr got %b want %b", e.nm, bus.StackErr, e.err);
    end
  endtask

  task automatic do_reset();
    cyc("rst", 1, 8'h37, 0,0,0, 8'h00, 0,1,0, 8'h99,
        8'h00, 3'd0, 1, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    cyc("rst_idle", 0, 8'h00, 0,0,0, 8'h00, 0,0,0, 8'h00,
        8'h01, 3'd0, 1, 0, 0);
  endtask

  task automatic test_branch();
    cyc("br_taken", 0, 8'h10, 0,1,1, 8'hFC, 0,0,0, 8'h00,
        8'h0D, 3'd0, 1, 0, 0);
    cyc("br_nt", 0, 8'h10, 0,1,0, 8'hFC, 0,0,0, 8'h00,
        8'h11, 3'd0, 1, 0, 0);
    cyc("wrap", 0, 8'hFF, 0,0,0, 8'h00, 0,0,0, 8'h00,
        8'h00, 3'd0, 1, 0, 0);
    cyc("zero_only", 0, 8'h10, 0,0,1, 8'h20, 0,0,0, 8'h00,
        8'h11, 3'd0, 1, 0, 0);
    cyc("jmp_over_br", 0, 8'h10, 0,1,1, 8'h20, 1,0,0, 8'h55,
        8'h55, 3'd0, 1, 0, 0);
    cyc("br_fwd_wrap", 0, 8'hF0, 0,1,1, 8'h20, 0,0,0, 8'h00,
        8'h11, 3'd0, 1, 0, 0);
  endtask

  task automatic test_call_ret();
    do_reset();
    cyc("call", 0, 8'h20, 0,0,0, 8'h00, 0,1,0, 8'h80,
        8'h80, 3'd1, 0, 0, 0);
    cyc("ret", 0, 8'h85, 0,0,0, 8'h00, 0,0,1, 8'h00,
        8'h21, 3'd0, 1, 0, 0);
  endtask

  task automatic test_overflow();
    logic [7:0] rets [4] = '{8'h06, 8'h05, 8'h04, 8'h03};
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cyc("ovf_call", 0, 8'(i), 0,0,0, 8'h00, 0,1,0, 8'(8'h80 + i),
          8'(8'h80 + i), (i >= 4) ? 3'd4 : 3'(i),
          0, i >= 4, i == 5);
    end
    for (int i = 0; i < 4; i++) begin
      cyc("ovf_ret", 0, 8'h50, 0,0,0, 8'h00, 0,0,1, 8'h00,
          rets[i], 3'(3 - i), i == 3, 0, STICKY);
    end
  endtask

  task automatic test_empty_ret();
    do_reset();
    cyc("empty_ret", 0, 8'h40, 0,0,0, 8'h00, 0,0,1, 8'h00,
        8'h41, 3'd0, 1, 0, 1);
    cyc("after_err", 0, 8'h41, 0,0,0, 8'h00, 0,0,0, 8'h00,
        8'h42, 3'd0, 1, 0, STICKY);
    cyc("stall_err", 0, 8'h42, 1,0,0, 8'h00, 0,0,0, 8'h00,
        8'h42, 3'd0, 1, 0, STICKY);
    do_reset();
  endtask

  task automatic test_stall();
    do_reset();
    cyc("stall_call", 0, 8'h12, 1,0,0, 8'h00, 0,1,0, 8'h90,
        8'h12, 3'd0, 1, 0, 0);
    cyc("jmp_call", 0, 8'h05, 0,0,0, 8'h00, 1,1,0, 8'h44,
        8'h44, 3'd1, 0, 0, 0);
    cyc("stall_ret", 0, 8'h44, 1,0,0, 8'h00, 0,0,1, 8'h00,
        8'h44, 3'd1, 0, 0, 0);
    cyc("jc_ret", 0, 8'h44, 0,0,0, 8'h00, 0,0,1, 8'h00,
        8'h06, 3'd0, 1, 0, 0);
  endtask

  task automatic test_conflict();
    do_reset();
    cyc("pre_call", 0, 8'h32, 0,0,0, 8'h00, 0,1,0, 8'h70,
        8'h70, 3'd1, 0, 0, 0);
    do_reset();
    cyc("ret_post_rst", 0, 8'h50, 0,0,0, 8'h00, 0,0,1, 8'h00,
        8'h51, 3'd0, 1, 0, 1);
    do_reset();
    cyc("push_33", 0, 8'h32, 0,0,0, 8'h00, 0,1,0, 8'h70,
        8'h70, 3'd1, 0, 0, 0);
    cyc("call_ret", 0, 8'h60, 0,0,0, 8'h00, 0,1,1, 8'h90,
        8'h33, 3'd0, 1, 0, 1);
    cyc("stall_hold", 0, 8'h61, 1,0,0, 8'h00, 0,0,1, 8'h00,
        8'h61, 3'd0, 1, 0, 1);
    cyc("post_hold", 0, 8'h61, 0,0,0, 8'h00, 0,0,0, 8'h00,
        8'h62, 3'd0, 1, 0, STICKY);
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc("b2b_c1", 0, 8'h10, 0,0,0, 8'h00, 0,1,0, 8'hA0,
        8'hA0, 3'd1, 0, 0, 0);
    cyc("b2b_c2", 0, 8'hA0, 0,0,0, 8'h00, 0,1,0, 8'hB0,
        8'hB0, 3'd2, 0, 0, 0);
    cyc("b2b_r1", 0, 8'hB0, 0,0,0, 8'h00, 0,0,1, 8'h00,
        8'hA1, 3'd1, 0, 0, 0);
    cyc("b2b_r2", 0, 8'hA1, 0,0,0, 8'h00, 0,0,1, 8'h00,
        8'h11, 3'd0, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_overflow();
    test_empty_ret();
    test_stall();
    test_conflict();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
